frankie_io_out_fifo: RTL and testbench
======================================

// Module: frankie_io_out_fifo
// PURPOSE
//  Downstream of the Frankie core's io_out port: captures every 16-bit word the core writes
//  with its IO-write instruction and drains it to an external device over valid/ready.
//  Decouples single-cycle core IO writes from a slower peripheral.
//  Provides a full flag the core's control unit uses to stall IO writes.
// PARAMETERS
//  WIDTH   16  data word width, matches Frankie datapath
//  DEPTH   8   FIFO entries; power of two, >= 2
//  AW      3   pointer width = log2(DEPTH)
// PORTS
//  clock      in   1        single clock; all state updates on posedge
//  reset      in   1        synchronous, active-low; sampled on posedge clock
//  io_out     in   WIDTH    word driven by the core
//  io_wr      in   1        core write strobe, one cycle per IO-write instruction
//  io_full    out  1        FIFO full; core must stall IO writes while high
//  dev_data   out  WIDTH    head-of-FIFO word to the device
//  dev_valid  out  1        dev_data is valid
//  dev_ready  in   1        device accepts dev_data this cycle
//  count      out  AW+1     current occupancy, 0..DEPTH
//  overflow   out  1        sticky: a write arrived while full and was dropped
//  ovf_clr    in   1        clears overflow
// BEHAVIOUR
//  - Reset (reset==0 at posedge): wr_ptr=rd_ptr=0, count=0, overflow=0; dev_valid=0,
//    io_full=0; storage contents not cleared. Reset mid-transfer discards all entries.
//  - First-word-fall-through: dev_data = mem[rd_ptr], dev_valid = (count!=0), both
//    combinational from registered state; no output latency beyond the storage write.
//  - push = io_wr & (!io_full | pop); pop = dev_valid & dev_ready.
//  - Write latency: word written at posedge N is on dev_data with dev_valid=1 after posedge N.
//  - push: mem[wr_ptr]<=io_out, wr_ptr<=wr_ptr+1. pop: rd_ptr<=rd_ptr+1.
//  - Pointers are AW bits and wrap modulo DEPTH (DEPTH-1 -> 0) without special-casing.
//  - count: +1 on push-only, -1 on pop-only, unchanged on push&pop or neither.
//  - io_full = (count==DEPTH); never exceeds DEPTH; never underflows below 0.
//  - Full and push&pop same cycle: both take effect, count stays DEPTH, no overflow.
//  - Empty: dev_valid=0 so pop cannot occur; dev_ready ignored; io_wr on an empty FIFO
//    is not bypassed — word appears the following cycle.
//  - io_wr while full with no pop: word dropped, state unchanged, overflow<=1.
//  - overflow: set has priority over ovf_clr in the same cycle; cleared by reset or ovf_clr.
//  - dev_data must hold stable while dev_valid=1 and dev_ready=0.
// CONFIGURATION
//  IO_OUT_STATS_EN defined: adds outputs words_sent [15:0] and words_dropped [15:0];
//    words_sent increments on every pop, words_dropped on every dropped write; both
//    reset to 0, wrap 0xFFFF->0x0000, not cleared by ovf_clr.
//  IO_OUT_STATS_EN undefined: neither port nor counter exists; all other behaviour identical.
// TESTING
//  1 reset=0 for 2 cycles with io_wr=1 -> count=0, dev_valid=0, overflow=0 after release.
//  2 dev_ready=0, write 0x0001..0x0008 -> count=8, io_full=1, dev_data=0x0001 held stable.
//  3 from full, write 0x0009 with dev_ready=0 -> dropped, overflow=1, count=8;
//    ovf_clr=1 -> overflow=0.
//  4 from full, io_wr=1 (0x0009) and dev_ready=1 same cycle -> count=8, device receives
//    0x0001..0x0009 in order after draining, no overflow.
//  5 dev_ready=1 always, write 20 words 0x0100+i back-to-back -> pointer wrap, device sees
//    0x0100..0x0113 in order, each one cycle after its write, count never >1.
//  6 3 words queued, assert reset=0 mid-drain -> dev_valid=0, count=0 next cycle;
//    with IO_OUT_STATS_EN, words_sent/words_dropped=0 and match counts in tests 2-5.

Source files
------------

// File: rtl/frankie_io_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : frankie_io_out_fifo
// Description : Output FIFO behind the Frankie core's io_out port. Captures
//               every word written by the core's IO-write instruction and
//               drains it to an external device over a valid/ready handshake.
//               It decouples single-cycle core IO writes from a slower
//               peripheral. io_full is the stall request for the core's
//               control unit.
//               Reads are first-word-fall-through: dev_data and dev_valid
//               come combinationally from registered state.
// Ports       :
//   clock         in   1        single clock, all state on posedge
//   reset         in   1        synchronous, active-low
//   io_out        in   WIDTH    word from the core
//   io_wr         in   1        core write strobe
//   io_full       out  1        FIFO full, core stalls IO writes
//   dev_data      out  WIDTH    head-of-FIFO word
//   dev_valid     out  1        dev_data is valid
//   dev_ready     in   1        device accepts dev_data
//   count         out  AW+1     occupancy 0..DEPTH
//   overflow      out  1        sticky: a write was dropped while full
//   ovf_clr       in   1        clears overflow
//   words_sent    out  16       (IO_OUT_STATS_EN only) pops, wrapping
//   words_dropped out  16       (IO_OUT_STATS_EN only) dropped writes, wrapping
// Options     : IO_OUT_STATS_EN -- adds the words_sent/words_dropped counters
// Revision    : 1.0 - initial release
// ============================================================================
module frankie_io_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_out,
  input  logic             io_wr,
  output logic             io_full,
  output logic [WIDTH-1:0] dev_data,
  output logic             dev_valid,
  input  logic             dev_ready,
  output logic [AW:0]      count,
  output logic             overflow,
  input  logic             ovf_clr
`ifdef IO_OUT_STATS_EN
  ,
  output logic [15:0]      words_sent,
  output logic [15:0]      words_dropped
`endif
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;

  logic w_full;
  logic w_valid;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_full  = (r_count == c_depth);
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & dev_ready;
  // A write into a full FIFO still succeeds if the head leaves in the same
  // cycle. The slot being freed is the one the write pointer already addresses.
  assign w_push  = io_wr & (~w_full | w_pop);
  assign w_drop  = io_wr & w_full & ~w_pop;

  assign io_full   = w_full;
  assign dev_valid = w_valid;
  assign dev_data  = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign overflow  = r_overflow;

  // Storage is not reset. Stale contents are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_out;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      // A drop in the same cycle as a clear wins, so the event is not lost.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef IO_OUT_STATS_EN
  logic [15:0] r_words_sent;
  logic [15:0] r_words_dropped;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_words_sent    <= '0;
      r_words_dropped <= '0;
    end else begin
      if (w_pop) begin
        r_words_sent <= r_words_sent + 1'b1;
      end
      if (w_drop) begin
        r_words_dropped <= r_words_dropped + 1'b1;
      end
    end
  end

  assign words_sent    = r_words_sent;
  assign words_dropped = r_words_dropped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frankie_io_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_frankie_io_out_fifo
// Description : Directed self-checking bench for frankie_io_out_fifo.
//               Inputs are driven and outputs sampled 1ns after each rising
//               clock edge. Define IO_OUT_STATS_EN to also check the
//               statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frankie_io_out_fifo;

  logic        clock;
  logic        reset;
  logic [15:0] io_out;
  logic        io_wr;
  logic        io_full;
  logic [15:0] dev_data;
  logic        dev_valid;
  logic        dev_ready;
  logic [3:0]  count;
  logic        overflow;
  logic        ovf_clr;
`ifdef IO_OUT_STATS_EN
  logic [15:0] words_sent;
  logic [15:0] words_dropped;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  frankie_io_out_fifo #(.WIDTH(16), .DEPTH(8), .AW(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .io_out    (io_out),
    .io_wr     (io_wr),
    .io_full   (io_full),
    .dev_data  (dev_data),
    .dev_valid (dev_valid),
    .dev_ready (dev_ready),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
`ifdef IO_OUT_STATS_EN
    ,
    .words_sent    (words_sent),
    .words_dropped (words_dropped)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; io_out = '0; io_wr = 1'b0; dev_ready = 1'b0; ovf_clr = 1'b0;
    #1;

    // 1: reset held two cycles with a write strobe asserted
    reset = 1'b0; io_wr = 1'b1; io_out = 16'hDEAD;
    tick(); tick();
    reset = 1'b1; io_wr = 1'b0;
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(dev_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_full", 32'(io_full), 32'd0);

    // Empty FIFO: dev_ready has no effect and nothing underflows
    dev_ready = 1'b1;
    tick();
    check("empty_no_underflow", 32'(count), 32'd0);
    dev_ready = 1'b0;

    // 2: fill to DEPTH with the device stalled
    for (int i = 1; i <= 8; i++) begin
      io_out = 16'(i); io_wr = 1'b1;
      if (i == 1) check("no_bypass_valid", 32'(dev_valid), 32'd0);
      tick();
      if (i == 1) begin
        check("first_latency_valid", 32'(dev_valid), 32'd1);
        check("first_latency_data", 32'(dev_data), 32'h0001);
      end
    end
    io_wr = 1'b0;
    check("fill_count", 32'(count), 32'd8);
    check("fill_full", 32'(io_full), 32'd1);
    check("fill_head", 32'(dev_data), 32'h0001);
    tick(); tick();
    check("head_stable", 32'(dev_data), 32'h0001);
    check("head_stable_valid", 32'(dev_valid), 32'd1);

    // 3: write while full with no pop is dropped
    io_out = 16'h0009; io_wr = 1'b1;
    tick();
    io_wr = 1'b0;
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd8);
    check("drop_head", 32'(dev_data), 32'h0001);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    // set wins over clear in the same cycle
    io_out = 16'h0077; io_wr = 1'b1; ovf_clr = 1'b1;
    tick();
    io_wr = 1'b0; ovf_clr = 1'b0;
    check("ovf_set_priority", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr2", 32'(overflow), 32'd0);

    // 4: push and pop together while full
    io_out = 16'h0009; io_wr = 1'b1; dev_ready = 1'b1;
    check("pp_head", 32'(dev_data), 32'h0001);
    tick();
    io_wr = 1'b0;
    check("pp_count", 32'(count), 32'd8);
    check("pp_ovf", 32'(overflow), 32'd0);
    for (int k = 2; k <= 9; k++) begin
      check($sformatf("drain_valid_%0d", k), 32'(dev_valid), 32'd1);
      check($sformatf("drain_data_%0d", k), 32'(dev_data), 32'(k));
      tick();
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid", 32'(dev_valid), 32'd0);

    // 5: streaming with the device always ready, pointers wrap
    for (int i = 0; i < 20; i++) begin
      io_out = 16'h0100 + 16'(i); io_wr = 1'b1;
      tick();
      check($sformatf("stream_data_%0d", i), 32'(dev_data), 32'h0100 + 32'(i));
      check($sformatf("stream_count_%0d", i), 32'(count), 32'd1);
    end
    io_wr = 1'b0;
    check("stream_last_valid", 32'(dev_valid), 32'd1);
    tick();
    check("stream_end_count", 32'(count), 32'd0);
    check("stream_end_ovf", 32'(overflow), 32'd0);
`ifdef IO_OUT_STATS_EN
    check("stats_sent", 32'(words_sent), 32'd29);
    check("stats_dropped", 32'(words_dropped), 32'd2);
`endif

    // 6: reset mid-drain discards queued words
    dev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      io_out = 16'h00A0 + 16'(i); io_wr = 1'b1;
      tick();
    end
    io_wr = 1'b0;
    check("q3_count", 32'(count), 32'd3);
    dev_ready = 1'b1;
    tick();
    check("q3_pop_count", 32'(count), 32'd2);
    check("q3_pop_head", 32'(dev_data), 32'h00A1);
    reset = 1'b0;
    tick();
    check("mid_rst_valid", 32'(dev_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_full", 32'(io_full), 32'd0);
`ifdef IO_OUT_STATS_EN
    check("mid_rst_sent", 32'(words_sent), 32'd0);
    check("mid_rst_dropped", 32'(words_dropped), 32'd0);
`endif
    reset = 1'b1; dev_ready = 1'b0;
    tick();
    check("post_rst_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
